color_attr_pipe: RTL and testbench
==================================

COLOR_ATTR_PIPE -- requirements
Module: color_attr_pipe

Interface
REQ-001 SHALL provide parameter RW, default 5, red output width, legal 2..8.
REQ-002 SHALL provide parameter GW, default 6, green output width, legal 2..8.
REQ-003 SHALL provide parameter BW, default 5, blue output width, legal 2..8.
REQ-004 SHALL provide parameter BLINK_DIV, default 16, frames per attribute-blink half period, legal >=1.
REQ-005 SHALL provide parameter CURSOR_DIV, default 8, frames per cursor-blink half period, legal >=1.
REQ-006 SHALL provide parameter BROWN_FIX, default 1, 1 enables the colour-6 green substitution.
REQ-007 SHALL have ports: i_clk  in  1  sole clock, all state on rising edge.
REQ-008 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-009 i_frame  in  1  one-cycle pulse, once per frame.
REQ-010 i_valid  in  1  pixel inputs valid this cycle.
REQ-011 i_attr  in  8  attribute {bg irgb[7:4], fg irgb[3:0]}.
REQ-012 i_fg  in  1  pixel is glyph foreground.
REQ-013 i_cursor  in  1  pixel lies in cursor area.
REQ-014 i_ble  in  1  1: attr[7] is blink bit, 0: attr[7] is bg intensity.
REQ-015 i_blank  in  1  pixel outside active area.
REQ-016 o_valid  out  1; o_red  out  RW; o_green  out  GW; o_blue  out  BW; o_blink  out  1 current attribute-blink phase.

Function
REQ-017 Attribute counter SHALL count i_frame pulses 0..BLINK_DIV-1; on pulse at BLINK_DIV-1 wrap to 0 and toggle blink phase (o_blink).
REQ-018 Cursor counter SHALL behave identically with CURSOR_DIV, toggling cursor phase; DIV=1 toggles every pulse.
REQ-019 Phase change caused by i_frame in cycle N SHALL affect pixels sampled in cycle N+1 onward, not cycle N.
REQ-020 Stage 1 SHALL register colour index: show_fg = i_fg & (~i_ble | ~i_attr[7] | blink phase).
REQ-021 Cursor: when i_cursor & cursor phase, show_fg SHALL be inverted after REQ-020.
REQ-022 Index SHALL be i_attr[3:0] if show_fg, else {1'b0,i_attr[6:4]} when i_ble=1, else i_attr[7:4].
REQ-023 i_blank=1 SHALL force stage-1 index 0 and force black output.
REQ-024 Stage 2 SHALL expand index {i,r,g,b}: channel bit at MSB-relative position k = colour bit for even k, i for odd k, per width.
REQ-025 With BROWN_FIX=1 and index 6, green bit k SHALL be 0 for even k, 1 for odd k; red/blue unchanged.
REQ-026 Latency SHALL be exactly 2 cycles inputs->outputs; o_valid = i_valid delayed 2; no stall, one pixel per cycle.
REQ-027 Outputs with o_valid=0 SHALL still reflect pipeline contents (no gating beyond REQ-023).

Reset
REQ-028 While i_rst_n=0: counters 0, blink and cursor phases 1, pipeline index 0, o_valid 0, RGB all 0.
REQ-029 Reset assertion mid-operation SHALL clear state immediately (asynchronous); first valid output 2 cycles after first post-release i_valid.

Verification
REQ-030 Defaults, attr=8'h1E, i_fg=1, i_ble=0, valid -> 2 cycles later red=5'b11111, green=6'b111111, blue=5'b01010.
REQ-031 BROWN_FIX=1, attr=8'h06, i_fg=1 -> red=5'b10101, green=6'b010101, blue=0; BROWN_FIX=0 -> green=6'b101010.
REQ-032 BLINK_DIV=2, i_ble=1, attr=8'h9F, i_fg=1 -> white; after 2 i_frame pulses o_blink=0, output blue 5'b10101 (bg 1); after 2 more, white again.
REQ-033 CURSOR_DIV=1, attr=8'h07, i_fg=0, i_cursor=1 -> alternates per frame between fg grey (R/G/B 10101,101010,10101) and black.
REQ-034 i_blank=1 with attr=8'hFF, i_fg=1 -> all outputs 0; o_valid still follows i_valid.
REQ-035 RW=GW=BW=8, attr=8'h0C -> red=8'hFF, green=8'h55, blue=8'h55; async reset mid-stream -> outputs 0 same cycle.

Source files
------------

// File: rtl/color_attr_pipe.sv
// color_attr_pipe: text-mode attribute to RGB pixel pipeline (2-cycle latency).
// Ports: i_clk, i_rst_n, i_frame, i_valid, i_attr, i_fg, i_cursor, i_ble, i_blank -> o_valid, o_red, o_green, o_blue, o_blink.
module color_attr_pipe #(
  parameter int RW         = 5,
  parameter int GW         = 6,
  parameter int BW         = 5,
  parameter int BLINK_DIV  = 16,
  parameter int CURSOR_DIV = 8,
  parameter int BROWN_FIX  = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_frame,
  input  logic          i_valid,
  input  logic [7:0]    i_attr,
  input  logic          i_fg,
  input  logic          i_cursor,
  input  logic          i_ble,
  input  logic          i_blank,
  output logic          o_valid,
  output logic [RW-1:0] o_red,
  output logic [GW-1:0] o_green,
  output logic [BW-1:0] o_blue,
  output logic          o_blink
);

  // Bit p of the result is set when its MSB-relative position (w-1-p)
  // is even; those bits carry the colour bit, the rest carry intensity.
  function automatic logic [7:0] even_mask(input int w);
    logic [7:0] m;
    m = '0;
    for (int p = 0; p < 8; p++) begin
      if (p < w && ((w - 1 - p) % 2 == 0)) begin
        m[p] = 1'b1;
      end
    end
    return m;
  endfunction

  localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int CCW = (CURSOR_DIV > 1) ? $clog2(CURSOR_DIV) : 1;

  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_DIV - 1);
  localparam logic [CCW-1:0] CUR_LAST   = CCW'(CURSOR_DIV - 1);

  localparam logic [RW-1:0] R_EVEN = RW'(even_mask(RW));
  localparam logic [GW-1:0] G_EVEN = GW'(even_mask(GW));
  localparam logic [BW-1:0] B_EVEN = BW'(even_mask(BW));

  logic [BCW-1:0] blink_cnt;
  logic [CCW-1:0] cur_cnt;
  logic           blink_ph;
  logic           cur_ph;

  logic           show_fg;
  logic [3:0]     idx_d;
  logic [3:0]     s1_idx;
  logic           s1_valid;

  logic           c_i;
  logic           c_r;
  logic           c_g;
  logic           c_b;
  logic [RW-1:0]  red_d;
  logic [GW-1:0]  green_d;
  logic [BW-1:0]  blue_d;

  // Frame-rate phase generators. A pulse at the last count wraps the
  // counter and flips the phase; the new phase is seen next cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
    end else if (i_frame) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + BCW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cur_cnt <= '0;
      cur_ph  <= 1'b1;
    end else if (i_frame) begin
      if (cur_cnt == CUR_LAST) begin
        cur_cnt <= '0;
        cur_ph  <= ~cur_ph;
      end else begin
        cur_cnt <= cur_cnt + CCW'(1);
      end
    end
  end

  assign o_blink = blink_ph;

  // Stage 1: pick fg or bg colour index.
  always_comb begin
    show_fg = i_fg & (~i_ble | ~i_attr[7] | blink_ph);
    if (i_cursor & cur_ph) begin
      show_fg = ~show_fg;
    end
    idx_d = 4'h0;
    if (i_blank) begin
      idx_d = 4'h0;
    end else if (show_fg) begin
      idx_d = i_attr[3:0];
    end else if (i_ble) begin
      idx_d = {1'b0, i_attr[6:4]};
    end else begin
      idx_d = i_attr[7:4];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_idx   <= 4'h0;
      s1_valid <= 1'b0;
    end else begin
      s1_idx   <= idx_d;
      s1_valid <= i_valid;
    end
  end

  // Stage 2: IRGB expansion, colour bit on even positions, intensity on odd.
  assign {c_i, c_r, c_g, c_b} = s1_idx;

  always_comb begin
    red_d   = ({RW{c_r}} & R_EVEN) | ({RW{c_i}} & ~R_EVEN);
    green_d = ({GW{c_g}} & G_EVEN) | ({GW{c_i}} & ~G_EVEN);
    blue_d  = ({BW{c_b}} & B_EVEN) | ({BW{c_i}} & ~B_EVEN);
    // Colour 6 shows as brown: half-intensity green pattern shifted.
    if (BROWN_FIX != 0 && s1_idx == 4'd6) begin
      green_d = ~G_EVEN;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_red   <= '0;
      o_green <= '0;
      o_blue  <= '0;
    end else begin
      o_valid <= s1_valid;
      o_red   <= red_d;
      o_green <= green_d;
      o_blue  <= blue_d;
    end
  end

endmodule

// File: tb/tb_color_attr_pipe.sv
// tb_color_attr_pipe: directed bench for color_attr_pipe, three parameter sets.
// Reference model tracks frame count and a 2-deep expected-pixel pipeline.
module tb_color_attr_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_frame = 1'b0;
  logic       i_valid = 1'b0;
  logic [7:0] i_attr = 8'h00;
  logic       i_fg = 1'b0;
  logic       i_cursor = 1'b0;
  logic       i_ble = 1'b0;
  logic       i_blank = 1'b0;

  logic       a_v, b_v, c_v;
  logic       a_bl, b_bl, c_bl;
  logic [4:0] a_r, b_r;
  logic [5:0] a_g, b_g;
  logic [4:0] a_b, b_b;
  logic [7:0] c_r, c_g, c_b;

  int n_checks = 0;
  int n_fail = 0;

  int p_rw [3] = '{5, 5, 8};
  int p_gw [3] = '{6, 6, 8};
  int p_bw [3] = '{5, 5, 8};
  int p_bd [3] = '{16, 2, 16};
  int p_cd [3] = '{8, 1, 8};
  int p_bf [3] = '{1, 0, 1};

  always #5 clk = ~clk;

  color_attr_pipe u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame(i_frame), .i_valid(i_valid),
    .i_attr(i_attr), .i_fg(i_fg), .i_cursor(i_cursor), .i_ble(i_ble),
    .i_blank(i_blank), .o_valid(a_v), .o_red(a_r), .o_green(a_g),
    .o_blue(a_b), .o_blink(a_bl)
  );

  color_attr_pipe #(
    .BLINK_DIV(2), .CURSOR_DIV(1), .BROWN_FIX(0)
  ) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame(i_frame), .i_valid(i_valid),
    .i_attr(i_attr), .i_fg(i_fg), .i_cursor(i_cursor), .i_ble(i_ble),
    .i_blank(i_blank), .o_valid(b_v), .o_red(b_r), .o_green(b_g),
    .o_blue(b_b), .o_blink(b_bl)
  );

  color_attr_pipe #(
    .RW(8), .GW(8), .BW(8)
  ) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame(i_frame), .i_valid(i_valid),
    .i_attr(i_attr), .i_fg(i_fg), .i_cursor(i_cursor), .i_ble(i_ble),
    .i_blank(i_blank), .o_valid(c_v), .o_red(c_r), .o_green(c_g),
    .o_blue(c_b), .o_blink(c_bl)
  );

  logic [26:0] got [3];
  assign got[0] = {a_v, a_bl, 1'b0, 3'b0, a_r, 2'b0, a_g, 3'b0, a_b};
  assign got[1] = {b_v, b_bl, 1'b0, 3'b0, b_r, 2'b0, b_g, 3'b0, b_b};
  assign got[2] = {c_v, c_bl, 1'b0, c_r, c_g, c_b};

  // ---------------- reference model ----------------
  int         nfr = 0;
  logic       mv1 = 1'b0;
  logic       mv2 = 1'b0;
  logic [3:0] m1 [3] = '{4'h0, 4'h0, 4'h0};
  logic [7:0] mr [3] = '{8'h0, 8'h0, 8'h0};
  logic [7:0] mg [3] = '{8'h0, 8'h0, 8'h0};
  logic [7:0] mb [3] = '{8'h0, 8'h0, 8'h0};

  // Phase starts at 1 and flips after every div frame pulses.
  function automatic bit phase(input int nf, input int div);
    return ((nf / div) % 2) == 0;
  endfunction

  // MSB first: even positions carry colour, odd ones intensity.
  function automatic logic [7:0] chan(input int w, input bit c,
                                      input bit i, input bit brown);
    logic [7:0] v;
    bit         b;
    v = 8'h00;
    for (int k = 0; k < w; k++) begin
      if (brown) b = (k % 2) == 1;
      else b = ((k % 2) == 0) ? c : i;
      v = {v[6:0], b};
    end
    return v;
  endfunction

  function automatic logic [3:0] ref_index(input int n);
    bit sf;
    sf = i_fg && (!i_ble || !i_attr[7] || phase(nfr, p_bd[n]));
    if (i_cursor && phase(nfr, p_cd[n])) sf = !sf;
    if (i_blank) return 4'h0;
    if (sf) return i_attr[3:0];
    if (i_ble) return {1'b0, i_attr[6:4]};
    return i_attr[7:4];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nfr = 0;
      mv1 = 1'b0;
      mv2 = 1'b0;
      for (int n = 0; n < 3; n++) begin
        m1[n] = 4'h0;
        mr[n] = 8'h0;
        mg[n] = 8'h0;
        mb[n] = 8'h0;
      end
    end else begin
      mv2 = mv1;
      for (int n = 0; n < 3; n++) begin
        mr[n] = chan(p_rw[n], m1[n][2], m1[n][3], 1'b0);
        mg[n] = chan(p_gw[n], m1[n][1], m1[n][3],
                     (p_bf[n] != 0) && (m1[n] == 4'd6));
        mb[n] = chan(p_bw[n], m1[n][0], m1[n][3], 1'b0);
        m1[n] = ref_index(n);
      end
      mv1 = i_valid;
      if (i_frame) nfr++;
    end
  end

  task automatic chk(input string name, input logic [31:0] g,
                     input logic [31:0] e);
    n_checks++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, g, e, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("model_dut%0d", n), {5'b0, got[n]},
          {5'b0, mv2, phase(nfr, p_bd[n]), 1'b0, mr[n], mg[n], mb[n]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame();
    i_frame = 1'b1;
    run(1);
    i_frame = 1'b0;
  endtask

  task automatic set_px(input logic [7:0] attr, input logic fg,
                        input logic cur, input logic ble,
                        input logic blank, input logic v);
    i_attr = attr;
    i_fg = fg;
    i_cursor = cur;
    i_ble = ble;
    i_blank = blank;
    i_valid = v;
  endtask

  initial begin
    rst_n = 1'b0;
    run(2);
    chk("rst_valid", {31'b0, a_v}, 32'd0);
    chk("rst_rgb", {16'b0, a_r, a_g, a_b}, 32'd0);
    chk("rst_blink", {31'b0, a_bl}, 32'd1);
    rst_n = 1'b1;

    set_px(8'h1E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run(1);
    chk("first_valid_lat1", {31'b0, a_v}, 32'd0);
    run(1);
    chk("first_valid_lat2", {31'b0, a_v}, 32'd1);
    chk("attr1e_red", {27'b0, a_r}, 32'h1F);
    chk("attr1e_green", {26'b0, a_g}, 32'h3F);
    chk("attr1e_blue", {27'b0, a_b}, 32'h0A);

    set_px(8'h06, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run(2);
    chk("brown_red", {27'b0, a_r}, 32'h15);
    chk("brown_green", {26'b0, a_g}, 32'h15);
    chk("brown_blue", {27'b0, a_b}, 32'h00);
    chk("nobrown_green", {26'b0, b_g}, 32'h2A);

    set_px(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    run(2);
    chk("blank_rgb", {16'b0, a_r, a_g, a_b}, 32'd0);
    chk("blank_valid", {31'b0, a_v}, 32'd1);
    set_px(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run(2);
    chk("invalid_valid", {31'b0, a_v}, 32'd0);
    chk("invalid_red", {27'b0, a_r}, 32'h1F);

    set_px(8'h0C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run(2);
    chk("w8_rgb", {8'b0, c_r, c_g, c_b}, 32'h00FF5555);

    set_px(8'h9F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    run(2);
    chk("blink_on_rgb", {16'b0, b_r, b_g, b_b}, 32'hFFFF);
    pulse_frame();
    pulse_frame();
    chk("blink_ph0", {31'b0, b_bl}, 32'd0);
    run(2);
    chk("blink_off_rgb", {16'b0, b_r, b_g, b_b}, {16'b0, 5'h00, 6'h00, 5'h15});
    pulse_frame();
    pulse_frame();
    chk("blink_ph1", {31'b0, b_bl}, 32'd1);
    run(2);
    chk("blink_back_rgb", {16'b0, b_r, b_g, b_b}, 32'hFFFF);

    set_px(8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    run(2);
    chk("cur_grey", {16'b0, b_r, b_g, b_b}, {16'b0, 5'h15, 6'h2A, 5'h15});
    pulse_frame();
    run(2);
    chk("cur_black", {16'b0, b_r, b_g, b_b}, 32'd0);
    pulse_frame();
    run(2);
    chk("cur_grey2", {16'b0, b_r, b_g, b_b}, {16'b0, 5'h15, 6'h2A, 5'h15});

    for (int i = 0; i < 60; i++) begin
      set_px(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0), 1'($urandom));
      i_frame = (i % 3) == 0;
      run(1);
    end
    i_frame = 1'b0;

    set_px(8'h0C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rgb", {8'b0, c_r, c_g, c_b}, 32'd0);
    chk("async_rst_valid", {31'b0, c_v}, 32'd0);
    chk("async_rst_blink", {31'b0, b_bl}, 32'd1);
    run(2);
    rst_n = 1'b1;
    run(1);
    chk("post_rst_lat1", {31'b0, c_v}, 32'd0);
    run(1);
    chk("post_rst_lat2", {31'b0, c_v}, 32'd1);
    chk("post_rst_red", {24'b0, c_r}, 32'hFF);
    run(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
